// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file writeback path.
//   REG_ADDR_W : width of a register address
//   DATA_W     : width of a register word
//   NUM_REGS   : number of architectural registers (one scoreboard bit each)
//   port_id_t  : identifies which writeback requester was granted
package regfile_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 16;
  localparam int NUM_REGS   = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

  typedef enum logic {
    PORT_ALU = 1'b0,
    PORT_LD  = 1'b1
  } port_id_t;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Writeback request bundle for the two requesters (ALU on port 0, load unit
// on port 1). Each port is a valid/ready handshake carrying a destination
// register and write data.
//   master : requester side  (drives valid/wa/data, receives ready)
//   slave  : scheduler side  (receives valid/wa/data, drives ready)
interface regfile_wb_scheduler_if;
  import regfile_pkg::*;

  logic      req0_valid;
  reg_addr_t req0_wa;
  word_t     req0_data;
  logic      req0_ready;

  logic      req1_valid;
  reg_addr_t req1_wa;
  word_t     req1_data;
  logic      req1_ready;

  modport master (
    output req0_valid, req0_wa, req0_data,
    input  req0_ready,
    output req1_valid, req1_wa, req1_data,
    input  req1_ready
  );

  modport slave (
    input  req0_valid, req0_wa, req0_data,
    output req0_ready,
    input  req1_valid, req1_wa, req1_data,
    output req1_ready
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request per port (bit 0 = ALU, bit 1 = load unit)
//   gnt[1:0]   : one-hot grant, combinational from req and last_grant;
//                a grant is only ever given to a requesting port and is
//                forced to 0 while reset is asserted.
// last_grant remembers the most recently granted port; on a tie the other
// port wins. It resets to PORT_LD so the ALU wins the first tie.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_id_t   last_grant;
  logic [1:0] gnt_raw;

  always_comb begin
    gnt_raw = 2'b00;
    case (req)
      2'b01:   gnt_raw = 2'b01;
      2'b10:   gnt_raw = 2'b10;
      2'b11:   gnt_raw = (last_grant == PORT_LD) ? 2'b01 : 2'b10;
      default: gnt_raw = 2'b00;
    endcase
  end

  // Ready must read 0 during reset even though the requesters may be valid.
  assign gnt = gnt_raw & {2{rst_n}};

  // Any grant is a completed transfer, since grant implies valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PORT_LD;
    end else if (|gnt) begin
      last_grant <= gnt[0] ? PORT_ALU : PORT_LD;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler with issue scoreboard.
//   clk, rst_n        : clock, asynchronous active-low reset
//   wb (slave)        : two writeback request ports (ALU, load unit)
//   issue_valid/_wa   : an instruction issuing that will write issue_wa
//   issue_stall       : issue_wa already has a write outstanding
//   rd_a1, rd_a2      : decode-stage read addresses
//   hazard            : either read address has a write outstanding
//   rf_wa/rf_data/rf_we : registered write port into the register file
//   pending           : scoreboard, one bit per register
// One request is accepted per cycle (round-robin on contention) and is
// presented to the register file on the following cycle. A register's
// pending bit sets when a writer issues and clears on the edge that commits
// a write to it; a simultaneous re-issue keeps it set.
module regfile_wb_scheduler
  import regfile_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_wb_scheduler_if.slave   wb,
  input  logic                    issue_valid,
  input  reg_addr_t               issue_wa,
  output logic                    issue_stall,
  input  reg_addr_t               rd_a1,
  input  reg_addr_t               rd_a2,
  output logic                    hazard,
  output reg_addr_t               rf_wa,
  output word_t                   rf_data,
  output logic                    rf_we,
  output logic [NUM_REGS-1:0]     pending
);

  logic [1:0]          req;
  logic [1:0]          gnt;
  logic                vld_p0;
  reg_addr_t           wa_p0;
  word_t               data_p0;
  logic                vld_p1;
  reg_addr_t           wa_p1;
  word_t               data_p1;
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  assign req = {wb.req1_valid, wb.req0_valid};

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign wb.req0_ready = gnt[0];
  assign wb.req1_ready = gnt[1];

  // Stage p0: select the granted request
  assign vld_p0  = |gnt;
  assign wa_p0   = gnt[1] ? wb.req1_wa   : wb.req0_wa;
  assign data_p0 = gnt[1] ? wb.req1_data : wb.req0_data;

  // Stage p1: registered write port; address/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      wa_p1   <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        wa_p1   <= wa_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign rf_we   = vld_p1;
  assign rf_wa   = wa_p1;
  assign rf_data = data_p1;

  assign issue_stall = issue_valid & pending_q[issue_wa];
  assign hazard      = pending_q[rd_a1] | pending_q[rd_a2];

  // Clear is applied before set so a same-edge set of the same register wins.
  // A commit to a register that is not pending clears a bit that is already 0.
  always_comb begin
    pending_d = pending_q;
    if (vld_p1) begin
      pending_d[wa_p1] = 1'b0;
    end
    if (issue_valid && !issue_stall) begin
      pending_d[issue_wa] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios followed by random
// traffic. A per-cycle reference model predicts grants, stall/hazard and the
// scoreboard; accepted writes are queued and a separate monitor pops and
// compares them whenever rf_we is seen.
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                issue_valid = 1'b0;
  reg_addr_t           issue_wa = '0;
  logic                issue_stall;
  reg_addr_t           rd_a1 = '0;
  reg_addr_t           rd_a2 = '0;
  logic                hazard;
  reg_addr_t           rf_wa;
  word_t               rf_data;
  logic                rf_we;
  logic [NUM_REGS-1:0] pending;

  regfile_wb_scheduler_if wb ();

  regfile_wb_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb          (wb),
    .issue_valid (issue_valid),
    .issue_wa    (issue_wa),
    .issue_stall (issue_stall),
    .rd_a1       (rd_a1),
    .rd_a2       (rd_a2),
    .hazard      (hazard),
    .rf_wa       (rf_wa),
    .rf_data     (rf_data),
    .rf_we       (rf_we),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    reg_addr_t wa;
    word_t     data;
  } wr_t;

  wr_t exp_q[$];

  // Reference model state
  bit        m_pend[NUM_REGS];
  int        m_last;           // port granted most recently
  bit        m_we;             // a write is being committed this cycle
  reg_addr_t m_wa;
  word_t     m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] pend_vec();
    logic [15:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_pend[i] = 1'b0;
    m_last = 1;
    m_we   = 1'b0;
    m_wa   = '0;
    m_data = '0;
    exp_q.delete();
  endtask

  // Monitor: every committed write must be the oldest accepted request.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rf_we", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("commit_wa", 32'(rf_wa), 32'(e.wa));
        chk("commit_data", 32'(rf_data), 32'(e.data));
      end
    end
  end

  // One clock cycle: inputs are already driven; compare at the falling edge,
  // then advance the model across the rising edge.
  task automatic step(output bit g0, output bit g1);
    bit v0, v1, stall, haz;
    reg_addr_t w0, w1;
    word_t d0, d1;
    @(negedge clk);
    v0 = wb.req0_valid; v1 = wb.req1_valid;
    w0 = wb.req0_wa;    w1 = wb.req1_wa;
    d0 = wb.req0_data;  d1 = wb.req1_data;
    g0 = 1'b0; g1 = 1'b0;
    if (v0 && v1) begin
      if (m_last == 1) g0 = 1'b1; else g1 = 1'b1;
    end else if (v0) g0 = 1'b1;
    else if (v1) g1 = 1'b1;
    stall = issue_valid && m_pend[issue_wa];
    haz   = m_pend[rd_a1] || m_pend[rd_a2];
    chk("req0_ready", 32'(wb.req0_ready), 32'(g0));
    chk("req1_ready", 32'(wb.req1_ready), 32'(g1));
    chk("issue_stall", 32'(issue_stall), 32'(stall));
    chk("hazard", 32'(hazard), 32'(haz));
    chk("pending", 32'(pending), 32'(pend_vec()));
    chk("rf_we", 32'(rf_we), 32'(m_we));
    chk("rf_wa_hold", 32'(rf_wa), 32'(m_wa));
    chk("rf_data_hold", 32'(rf_data), 32'(m_data));
    if (g0) begin exp_q.push_back('{wa: w0, data: d0}); m_last = 0; end
    if (g1) begin exp_q.push_back('{wa: w1, data: d1}); m_last = 1; end
    @(posedge clk);
    if (m_we) m_pend[m_wa] = 1'b0;
    if (issue_valid && !stall) m_pend[issue_wa] = 1'b1;
    m_we = g0 | g1;
    if (g0) begin m_wa = w0; m_data = d0; end
    if (g1) begin m_wa = w1; m_data = d1; end
    #1;
  endtask

  task automatic idle_inputs();
    wb.req0_valid = 1'b0; wb.req1_valid = 1'b0;
    issue_valid = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    wb.req0_valid = 1'b1; wb.req1_valid = 1'b1;
    #1;
    chk({tag, "_rf_we"}, 32'(rf_we), 32'd0);
    chk({tag, "_rf_wa"}, 32'(rf_wa), 32'd0);
    chk({tag, "_rf_data"}, 32'(rf_data), 32'd0);
    chk({tag, "_pending"}, 32'(pending), 32'd0);
    chk({tag, "_ready"}, 32'({wb.req1_ready, wb.req0_ready}), 32'd0);
    idle_inputs();
  endtask

  initial begin
    bit g0, g1;
    wb.req0_valid = 1'b0; wb.req0_wa = '0; wb.req0_data = '0;
    wb.req1_valid = 1'b0; wb.req1_wa = '0; wb.req1_data = '0;
    model_reset();

    // Power-on reset
    repeat (2) @(posedge clk);
    #2;
    reset_checks("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset release then single ALU write to a pending register
    step(g0, g1);
    issue_valid = 1'b1; issue_wa = 4'd8;
    step(g0, g1);
    issue_valid = 1'b0;
    wb.req0_valid = 1'b1; wb.req0_wa = 4'd8; wb.req0_data = 16'h8A37;
    step(g0, g1);
    wb.req0_valid = 1'b0;
    step(g0, g1);
    step(g0, g1);

    // Load-unit write to a register that is not pending
    wb.req1_valid = 1'b1; wb.req1_wa = 4'd7; wb.req1_data = 16'h0777;
    step(g0, g1);
    wb.req1_valid = 1'b0;
    step(g0, g1);
    step(g0, g1);

    // Hazard on a pending register and stalled re-issue
    issue_valid = 1'b1; issue_wa = 4'd15;
    step(g0, g1);
    rd_a1 = 4'd15;
    step(g0, g1);
    step(g0, g1);
    issue_valid = 1'b0;
    wb.req1_valid = 1'b1; wb.req1_wa = 4'd15; wb.req1_data = 16'hF00F;
    step(g0, g1);
    wb.req1_valid = 1'b0;
    step(g0, g1);
    step(g0, g1);
    rd_a1 = '0;

    // Same-edge commit and re-issue of register 5
    wb.req0_valid = 1'b1; wb.req0_wa = 4'd5; wb.req0_data = 16'h0505;
    step(g0, g1);
    wb.req0_valid = 1'b0;
    issue_valid = 1'b1; issue_wa = 4'd5;
    step(g0, g1);
    issue_valid = 1'b0;
    rd_a2 = 4'd5;
    step(g0, g1);
    step(g0, g1);
    rd_a2 = '0;

    // Reset in the cycle after a transfer drops the registered write
    issue_valid = 1'b1; issue_wa = 4'd3;
    wb.req0_valid = 1'b1; wb.req0_wa = 4'd3; wb.req0_data = 16'h0104;
    step(g0, g1);
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    reset_checks("midrst");
    @(negedge clk);
    chk("midrst_rf_we_neg", 32'(rf_we), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(g0, g1);

    // Contention: both ports valid for four cycles
    wb.req0_valid = 1'b1; wb.req0_wa = 4'd1; wb.req0_data = 16'h1000;
    wb.req1_valid = 1'b1; wb.req1_wa = 4'd2; wb.req1_data = 16'h2000;
    for (int i = 0; i < 4; i++) begin
      step(g0, g1);
      chk("contention_grant0", 32'(g0), 32'((i % 2) == 0));
      if (g0) wb.req0_data = wb.req0_data + 16'd1;
      if (g1) wb.req1_data = wb.req1_data + 16'd1;
    end
    idle_inputs();
    step(g0, g1);
    step(g0, g1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_wa    = reg_addr_t'($urandom_range(0, 15));
      rd_a1       = reg_addr_t'($urandom_range(0, 15));
      rd_a2       = reg_addr_t'($urandom_range(0, 15));
      if (!wb.req0_valid || g0) begin
        wb.req0_valid = ($urandom_range(0, 1) == 1);
        wb.req0_wa    = reg_addr_t'($urandom_range(0, 15));
        wb.req0_data  = word_t'($urandom);
      end
      if (!wb.req1_valid || g1) begin
        wb.req1_valid = ($urandom_range(0, 1) == 1);
        wb.req1_wa    = reg_addr_t'($urandom_range(0, 15));
        wb.req1_data  = word_t'($urandom);
      end
      step(g0, g1);
    end
    idle_inputs();
    step(g0, g1);
    step(g0, g1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
